// File: rtl/lfsr_8bit_checker_if.sv
// rtl/lfsr_8bit_checker_if.sv - PRBS checker bit stream and status bundle
// master drives the sampled stream, slave is the checker.
interface lfsr_8bit_checker_if #(
  parameter int CNT_W = 32
);
  logic             clk_en;
  logic             data_in;
  logic             clear_cnt;
  logic             locked;
  logic             err_strobe;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output clk_en, data_in, clear_cnt,
    input  locked, err_strobe, err_count, bit_count
  );

  modport slave (
    input  clk_en, data_in, clear_cnt,
    output locked, err_strobe, err_count, bit_count
  );
endinterface

// File: rtl/lfsr_8bit_checker.sv
// rtl/lfsr_8bit_checker.sv - self-synchronising x^8+x^6+x^5+x^4+1 PRBS bit error checker
// Optional feature macro: LFSR8_CHK_COUNTERS_EN (error/bit counters and clear_cnt).
module lfsr_8bit_checker #(
  parameter int LOCK_COUNT  = 16,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  lfsr_8bit_checker_if.slave   bus
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST = 8'(LOSS_THRESH - 1);
  localparam logic [7:0] WIN_LAST  = 8'd254;

  state_t     state;
  logic [7:0] h;
  logic [3:0] fill_cnt;
  logic [7:0] match_cnt;
  logic [7:0] win_cnt;
  logic [7:0] win_err;
  logic       locked_q;
  logic       strobe_q;

  logic p;
  logic match;
  logic search_hit;

  assign p          = h[7] ^ h[5] ^ h[4] ^ h[3];
  assign match      = (p == bus.data_in);
  // An all-zero history predicts zero forever, so it never counts toward lock.
  assign search_hit = match && (h != 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      h         <= 8'd0;
      fill_cnt  <= 4'd0;
      match_cnt <= 8'd0;
      win_cnt   <= 8'd0;
      win_err   <= 8'd0;
      locked_q  <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (bus.clk_en) begin
        case (state)
          SEARCH: begin
            h <= {h[6:0], bus.data_in};
            if (fill_cnt != 4'd8) begin
              fill_cnt <= fill_cnt + 4'd1;
            end else if (!search_hit) begin
              match_cnt <= 8'd0;
            end else if (match_cnt == LOCK_LAST) begin
              state     <= LOCKED;
              locked_q  <= 1'b1;
              match_cnt <= 8'd0;
              win_cnt   <= 8'd0;
              win_err   <= 8'd0;
            end else begin
              match_cnt <= match_cnt + 8'd1;
            end
          end
          LOCKED: begin
            // Reference free-runs on its own prediction so line errors do not propagate.
            h <= {h[6:0], p};
            if (!match) begin
              strobe_q <= 1'b1;
            end
            if (!match && (win_err == LOSS_LAST)) begin
              state     <= SEARCH;
              locked_q  <= 1'b0;
              fill_cnt  <= 4'd0;
              match_cnt <= 8'd0;
            end else if (win_cnt == WIN_LAST) begin
              win_cnt <= 8'd0;
              win_err <= 8'd0;
            end else begin
              win_cnt <= win_cnt + 8'd1;
              if (!match) begin
                win_err <= win_err + 8'd1;
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.locked     = locked_q;
  assign bus.err_strobe = strobe_q;

`ifdef LFSR8_CHK_COUNTERS_EN
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] bits_q;
  logic             checking;

  assign checking = bus.clk_en && (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst || bus.clear_cnt) begin
      err_q  <= '0;
      bits_q <= '0;
    end else if (checking) begin
      if (bits_q != '1) begin
        bits_q <= bits_q + CNT_W'(1);
      end
      if (!match && (err_q != '1)) begin
        err_q <= err_q + CNT_W'(1);
      end
    end
  end

  assign bus.err_count = err_q;
  assign bus.bit_count = bits_q;
`else
  logic unused_clear_cnt;

  assign unused_clear_cnt = bus.clear_cnt;
  assign bus.err_count    = '0;
  assign bus.bit_count    = '0;
`endif

endmodule

// File: tb/tb_lfsr_8bit_checker.sv
// tb/tb_lfsr_8bit_checker.sv - scoreboard bench for lfsr_8bit_checker
// Counter expectations follow LFSR8_CHK_COUNTERS_EN, as the design does.
module tb_lfsr_8bit_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lfsr_8bit_checker_if #(.CNT_W(32)) bus ();

  lfsr_8bit_checker #(
    .LOCK_COUNT (16),
    .LOSS_THRESH(8),
    .CNT_W      (32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef LFSR8_CHK_COUNTERS_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    string tag;
    logic  lk;
    logic  st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  logic [7:0] g;
  logic prev_lk;
  int   exp_err;
  int   exp_bits;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Monitor: one expectation per clock edge, popped just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, ".locked"}, 32'(bus.locked), 32'(mon_e.lk));
      check({mon_e.tag, ".err_strobe"}, 32'(bus.err_strobe), 32'(mon_e.st));
    end
  end

  task automatic prbs(output logic b);
    b = g[7];
    g = {g[6:0], g[7] ^ g[5] ^ g[4] ^ g[3]};
  endtask

  task automatic apply(input string tag, input logic r, input logic en, input logic d,
                       input logic clr, input logic lk, input logic st);
    exp_t e;
    rst           = r;
    bus.clk_en    = en;
    bus.data_in   = d;
    bus.clear_cnt = clr;
    e.tag = tag;
    e.lk  = lk;
    e.st  = st;
    exp_q.push_back(e);
    if (r || clr) begin
      exp_err  = 0;
      exp_bits = 0;
    end else if (en && prev_lk) begin
      exp_bits++;
      if (st) exp_err++;
    end
    prev_lk = r ? 1'b0 : lk;
  endtask

  task automatic drive(input string tag, input logic r, input logic en, input logic d,
                       input logic clr, input logic lk, input logic st);
    @(negedge clk);
    apply(tag, r, en, d, clr, lk, st);
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk);
    check({tag, ".err_count"}, bus.err_count, CNT_ON ? 32'(exp_err) : 32'd0);
    check({tag, ".bit_count"}, bus.bit_count, CNT_ON ? 32'(exp_bits) : 32'd0);
    apply(tag, 1'b0, 1'b0, 1'b0, 1'b0, prev_lk, 1'b0);
  endtask

  // lock_at = 0: lock state is expected to stay as it is.
  task automatic send_clean(input string tag, input int n, input int lock_at, input int gap);
    logic b;
    for (int i = 1; i <= n; i++) begin
      prbs(b);
      drive(tag, 1'b0, 1'b1, b, 1'b0, (lock_at == 0) ? prev_lk : (i >= lock_at), 1'b0);
      for (int k = 0; k < gap; k++) begin
        drive(tag, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, prev_lk, 1'b0);
      end
    end
  endtask

  // loss_at = 0: no loss expected within this burst.
  task automatic send_err(input string tag, input int n, input int loss_at);
    logic b;
    for (int i = 1; i <= n; i++) begin
      prbs(b);
      drive(tag, 1'b0, 1'b1, ~b, 1'b0, (i == loss_at) ? 1'b0 : prev_lk, prev_lk);
    end
  endtask

  task automatic send_const(input string tag, input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      drive(tag, 1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bus.clk_en    = 1'b0;
    bus.data_in   = 1'b0;
    bus.clear_cnt = 1'b0;
    g        = 8'h01;
    prev_lk  = 1'b0;
    exp_err  = 0;
    exp_bits = 0;

    drive("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_counts("reset");

    send_clean("lock", 24, 24, 0);
    send_clean("run", 1000, 0, 0);
    check_counts("run");

    send_err("single", 1, 0);
    send_clean("after_single", 20, 0, 0);
    check_counts("single");

    send_err("loss", 8, 8);
    check_counts("loss");
    send_clean("relock", 24, 24, 0);

    // 7 errors either side of a window wrap must not drop lock; the 8th in one window does.
    send_err("win_a", 7, 0);
    send_clean("win_a", 248, 0, 0);
    send_err("win_b", 7, 0);
    send_clean("win_b", 1, 0, 0);
    send_err("win_c", 1, 1);
    check_counts("win_c");

    drive("rst_s0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_const("stuck0", 500, 1'b0);
    check_counts("stuck0");
    drive("rst_s1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_const("stuck1", 500, 1'b1);
    check_counts("stuck1");

    drive("rst_sp", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    g = 8'h01;
    send_clean("sparse", 24, 24, 2);
    send_clean("sparse_run", 10, 0, 2);
    check_counts("sparse_run");
    begin
      logic b;
      prbs(b);
      drive("clr_err", 1'b0, 1'b1, ~b, 1'b1, 1'b1, 1'b1);
    end
    check_counts("clr_err");

    drive("midrst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_counts("midrst");
    send_clean("relock2", 24, 24, 0);
    send_clean("relock2_run", 5, 0, 0);
    check_counts("relock2");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
